// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Boot-time loader for the fetch-stage instruction memory. Consumes a byte
//   stream laid out as: 32-bit word count, that many program words, and a
//   32-bit XOR checksum. All fields are little-endian. Each program word is
//   written to consecutive byte addresses starting at BASE_ADDR. The loader
//   then either releases the PC (loader_done) or rejects the image
//   (loader_err).
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   rx_data[7:0]  stream byte
//   rx_valid      rx_data valid
//   rx_ready      loader accepts a byte this cycle
//   imem_we       one-cycle write strobe per assembled word
//   imem_waddr    write byte address (held between writes)
//   imem_wdata    write data (held between writes)
//   loader_done   image written and checksum matched (sticky)
//   loader_err    header out of range or checksum mismatch (sticky)
//   words_loaded  number of words written so far
module imem_boot_loader #(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        loader_done,
  output logic        loader_err,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_byte_cnt;
  logic [23:0] r_asm;        // first three bytes of the word in flight
  logic [31:0] r_word_count;
  logic [31:0] r_csum;
  logic        r_we;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic [15:0] r_words;

  logic        w_hs;
  logic        w_word_end;
  logic [31:0] w_word;
  logic        w_hdr_bad;
  logic        w_last_word;

  assign w_hs       = rx_valid && rx_ready;
  assign w_word_end = w_hs && (r_byte_cnt == 2'd3);
  // The 4th byte completes the word combinationally, so the header check,
  // the write and the checksum compare all act on the handshake edge.
  assign w_word     = {rx_data, r_asm};
  assign w_hdr_bad  = (w_word == 32'd0) || (w_word > 32'(IMEM_DEPTH));
  // r_words still counts words before this one, hence the +1.
  assign w_last_word = (({16'd0, r_words} + 32'd1) == r_word_count);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_HDR;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR:  if (w_word_end) w_next = w_hdr_bad ? S_ERR : S_DATA;
      S_DATA: if (w_word_end && w_last_word) w_next = S_CSUM;
      S_CSUM: if (w_word_end) w_next = (w_word == r_csum) ? S_DONE : S_ERR;
      default: w_next = r_state;
    endcase
  end

  // Outputs decoded from state; rx_ready is also gated by rst so that no
  // byte is consumed while reset is held.
  always_comb begin
    rx_ready    = 1'b0;
    loader_done = 1'b0;
    loader_err  = 1'b0;
    case (r_state)
      S_HDR, S_DATA, S_CSUM: rx_ready = !rst;
      S_DONE:                loader_done = 1'b1;
      S_ERR:                 loader_err  = 1'b1;
      default:               rx_ready    = 1'b0;
    endcase
  end

  // Byte assembly, word writes and running checksum
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt   <= 2'd0;
      r_asm        <= 24'd0;
      r_word_count <= 32'd0;
      r_csum       <= 32'd0;
      r_we         <= 1'b0;
      r_waddr      <= BASE_ADDR;
      r_wdata      <= 32'd0;
      r_words      <= 16'd0;
    end else begin
      r_we <= w_word_end && (r_state == S_DATA);
      if (w_hs) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0:    r_asm[7:0]   <= rx_data;
          2'd1:    r_asm[15:8]  <= rx_data;
          2'd2:    r_asm[23:16] <= rx_data;
          default: r_asm        <= r_asm;
        endcase
      end
      if (w_word_end) begin
        case (r_state)
          S_HDR: r_word_count <= w_word;
          S_DATA: begin
            r_wdata <= w_word;
            r_waddr <= BASE_ADDR + {14'd0, r_words, 2'b00};
            r_words <= r_words + 16'd1;
            r_csum  <= r_csum ^ w_word;
          end
          default: r_csum <= r_csum;
        endcase
      end
    end
  end

  assign imem_we      = r_we;
  assign imem_waddr   = r_waddr;
  assign imem_wdata   = r_wdata;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader. Instance A uses IMEM_DEPTH=4 and
// base 0; instance B uses the default depth and base 0x100. Both share the
// clock, reset and data bus, but each has its own rx_valid.
module tb_imem_boot_loader;

  localparam logic [31:0] BASE_B = 32'h0000_0100;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  rx_data;
  logic        v_a, v_b;

  logic        rdy_a, we_a, done_a, err_a;
  logic [31:0] waddr_a, wdata_a;
  logic [15:0] wl_a;
  logic        rdy_b, we_b, done_b, err_b;
  logic [31:0] waddr_b, wdata_b;
  logic [15:0] wl_b;

  imem_boot_loader #(.IMEM_DEPTH(4), .BASE_ADDR(32'h0)) dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(v_a), .rx_ready(rdy_a),
    .imem_we(we_a), .imem_waddr(waddr_a), .imem_wdata(wdata_a),
    .loader_done(done_a), .loader_err(err_a), .words_loaded(wl_a));

  imem_boot_loader #(.IMEM_DEPTH(1024), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(v_b), .rx_ready(rdy_b),
    .imem_we(we_b), .imem_waddr(waddr_b), .imem_wdata(wdata_b),
    .loader_done(done_b), .loader_err(err_b), .words_loaded(wl_b));

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] wl;
  } wr_t;

  wr_t  qa[$];
  wr_t  qb[$];
  int   dbl = 0;
  logic pa = 1'b0, pb = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  logic [31:0] img [4];

  // Write monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (we_a) qa.push_back({waddr_a, wdata_a, wl_a});
    if (we_b) qb.push_back({waddr_b, wdata_b, wl_b});
    if (we_a && pa) dbl++;
    if (we_b && pb) dbl++;
    pa = we_a;
    pb = we_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input int which, input logic [7:0] b, input bit stall);
    int t;
    if (stall && $urandom_range(0, 2) == 0) begin
      int gap;
      gap = $urandom_range(1, 10);
      for (int g = 0; g < gap; g++) begin
        rx_data = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_data = b;
    if (which == 0) v_a = 1'b1; else v_b = 1'b1;
    t = 0;
    while (!((which == 0) ? rdy_a : rdy_b) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) begin
      nvec++;
      nerr++;
      $error("FAIL rx_ready_timeout: observed 0 expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    v_a = 1'b0;
    v_b = 1'b0;
  endtask

  task automatic send_word(input int which, input logic [31:0] w, input bit stall);
    logic [31:0] tmp;
    tmp = w;
    for (int k = 0; k < 4; k++) send_byte(which, tmp[8*k +: 8], stall);
  endtask

  task automatic send_image(input int which, input int n, input logic [31:0] cs, input bit stall);
    send_word(which, 32'(n), stall);
    for (int i = 0; i < n; i++) send_word(which, img[i], stall);
    send_word(which, cs, stall);
  endtask

  task automatic chk_writes(input int which, input int n, input logic [31:0] base);
    wr_t q[$];
    if (which == 0) q = qa; else q = qb;
    chk("write_count", 32'(q.size()), 32'(n));
    for (int i = 0; i < n && i < q.size(); i++) begin
      chk("write_addr", q[i].a, base + 32'(4 * i));
      chk("write_data", q[i].d, img[i]);
      chk("words_loaded_at_we", {16'd0, q[i].wl}, 32'(i + 1));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    qa.delete();
    qb.delete();
  endtask

  initial begin
    logic [31:0] cs;
    rst = 1'b1;
    rx_data = 8'h00;
    v_a = 1'b0;
    v_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_in_rst_a", {31'd0, rdy_a}, 32'd0);
    chk("ready_in_rst_b", {31'd0, rdy_b}, 32'd0);
    rst = 1'b0;
    #1;

    // Reset values
    chk("rst_ready_a", {31'd0, rdy_a}, 32'd1);
    chk("rst_we_a", {31'd0, we_a}, 32'd0);
    chk("rst_waddr_a", waddr_a, 32'd0);
    chk("rst_wdata_a", wdata_a, 32'd0);
    chk("rst_done_a", {31'd0, done_a}, 32'd0);
    chk("rst_err_a", {31'd0, err_a}, 32'd0);
    chk("rst_wl_a", {16'd0, wl_a}, 32'd0);
    chk("rst_waddr_b", waddr_b, BASE_B);
    chk("rst_ready_b", {31'd0, rdy_b}, 32'd1);

    // Nominal two-word load
    img[0] = 32'h0050_0093;
    img[1] = 32'h00A0_0113;
    cs = img[0] ^ img[1];
    chk("csum_model", cs, 32'h00F0_0180);
    @(negedge clk);
    send_image(0, 2, cs, 1'b0);
    chk("nom_done", {31'd0, done_a}, 32'd1);
    chk("nom_err", {31'd0, err_a}, 32'd0);
    chk("nom_ready", {31'd0, rdy_a}, 32'd0);
    chk("nom_wl", {16'd0, wl_a}, 32'd2);
    chk_writes(0, 2, 32'h0);
    repeat (3) @(negedge clk);
    chk("hold_waddr", waddr_a, 32'h4);
    chk("hold_wdata", wdata_a, img[1]);
    chk("done_sticky", {31'd0, done_a}, 32'd1);

    // Bad checksum
    do_reset();
    chk("rst_done_cleared", {31'd0, done_a}, 32'd0);
    send_image(0, 2, 32'h0, 1'b0);
    chk_writes(0, 2, 32'h0);
    chk("badcs_err", {31'd0, err_a}, 32'd1);
    chk("badcs_done", {31'd0, done_a}, 32'd0);
    chk("badcs_ready", {31'd0, rdy_a}, 32'd0);

    // Header bounds: count 0 and count 5 with depth 4
    do_reset();
    send_word(0, 32'd0, 1'b0);
    chk("hdr0_err", {31'd0, err_a}, 32'd1);
    chk("hdr0_ready", {31'd0, rdy_a}, 32'd0);
    chk("hdr0_done", {31'd0, done_a}, 32'd0);
    chk("hdr0_writes", 32'(qa.size()), 32'd0);
    do_reset();
    send_word(0, 32'd5, 1'b0);
    chk("hdr5_err", {31'd0, err_a}, 32'd1);
    chk("hdr5_ready", {31'd0, rdy_a}, 32'd0);
    chk("hdr5_writes", 32'(qa.size()), 32'd0);

    // Stalled stream
    do_reset();
    send_image(0, 2, cs, 1'b1);
    chk_writes(0, 2, 32'h0);
    chk("stall_done", {31'd0, done_a}, 32'd1);
    chk("stall_single_pulse", 32'(dbl), 32'd0);

    // Reset mid-word; a byte offered during reset must be discarded
    do_reset();
    send_word(0, 32'd2, 1'b0);
    send_byte(0, 8'h93, 1'b0);
    send_byte(0, 8'h00, 1'b0);
    rst = 1'b1;
    rx_data = 8'hFF;
    v_a = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    v_a = 1'b0;
    #1;
    chk("midrst_we", {31'd0, we_a}, 32'd0);
    chk("midrst_wl", {16'd0, wl_a}, 32'd0);
    chk("midrst_ready", {31'd0, rdy_a}, 32'd1);
    chk("midrst_writes", 32'(qa.size()), 32'd0);
    send_image(0, 2, cs, 1'b0);
    chk_writes(0, 2, 32'h0);
    chk("midrst_done", {31'd0, done_a}, 32'd1);

    // Largest legal count (IMEM_DEPTH=4)
    do_reset();
    img[2] = 32'hDEAD_BEEF;
    img[3] = 32'h1234_5678;
    cs = img[0] ^ img[1] ^ img[2] ^ img[3];
    send_image(0, 4, cs, 1'b0);
    chk_writes(0, 4, 32'h0);
    chk("max_done", {31'd0, done_a}, 32'd1);
    chk("max_err", {31'd0, err_a}, 32'd0);

    // Non-zero base on instance B
    do_reset();
    img[0] = 32'h0010_0093;
    img[1] = 32'h0020_0113;
    img[2] = 32'h0020_81B3;
    cs = img[0] ^ img[1] ^ img[2];
    send_image(1, 3, cs, 1'b0);
    chk_writes(1, 3, BASE_B);
    chk("base_done", {31'd0, done_b}, 32'd1);
    chk("base_err", {31'd0, err_b}, 32'd0);
    chk("base_wl", {16'd0, wl_b}, 32'd3);
    chk("base_a_idle_writes", 32'(qa.size()), 32'd0);
    chk("final_single_pulse", 32'(dbl), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
